// File: rtl/wb_keys_pkg.sv
// Shared definitions for the wb_keys push-button / slide-switch Wishbone responder:
// register offsets, default bus window and small decode helpers.
package wb_keys_pkg;

  localparam logic [11:0] DATA_OFS     = 12'h000;
  localparam logic [11:0] RISE_OFS     = 12'h004;
  localparam logic [11:0] FALL_OFS     = 12'h008;
  localparam logic [11:0] IRQ_EN_OFS   = 12'h00C;
  localparam logic [11:0] IRQ_PEND_OFS = 12'h010;

  localparam logic [31:0] WB_KEYS_BASE = 32'h1000_1000;
  localparam logic [31:0] WB_KEYS_SIZE = 32'h0000_1000;

  typedef enum logic [2:0] {
    SEL_DATA     = 3'd0,
    SEL_RISE     = 3'd1,
    SEL_FALL     = 3'd2,
    SEL_IRQ_EN   = 3'd3,
    SEL_IRQ_PEND = 3'd4,
    SEL_NONE     = 3'd5
  } reg_sel_e;

  // Only the word offset inside the 4 KiB window selects a register.
  function automatic reg_sel_e decode_reg(input logic [31:0] adr);
    reg_sel_e sel;
    case ({adr[11:2], 2'b00})
      DATA_OFS:     sel = SEL_DATA;
      RISE_OFS:     sel = SEL_RISE;
      FALL_OFS:     sel = SEL_FALL;
      IRQ_EN_OFS:   sel = SEL_IRQ_EN;
      IRQ_PEND_OFS: sel = SEL_IRQ_PEND;
      default:      sel = SEL_NONE;
    endcase
    return sel;
  endfunction

  function automatic logic [31:0] byte_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/wb_if.sv
// Wishbone pipelined bus bundle shared by masters and slaves on the interconnect.
interface wb_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_m;
  logic [31:0] dat_s;
  logic        ack;
  logic        stall;
  logic        err;

  modport master (output cyc, stb, we, adr, sel, dat_m,
                  input  dat_s, ack, stall, err);
  modport slave  (input  cyc, stb, we, adr, sel, dat_m,
                  output dat_s, ack, stall, err);
endinterface

// File: rtl/wb_keys_debounce.sv
// key_debounce: one input bit through a 2-flop synchronizer and a stable-count
// debouncer; emits the debounced level plus one-cycle rise/fall pulses.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic db_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q, sync_d;
  logic          db_q, db_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Next-state: the counter only runs while the synchronized level disagrees with db.
  always_comb begin
    sync_d = {sync_q[0], raw_i};
    db_d   = db_q;
    cnt_d  = cnt_q;
    if (sync_q[1] == db_q) begin
      cnt_d = {CW{1'b0}};
    end else if (cnt_q == CNT_MAX) begin
      db_d  = sync_q[1];
      cnt_d = {CW{1'b0}};
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
      db_q   <= 1'b0;
      cnt_q  <= {CW{1'b0}};
    end else begin
      sync_q <= sync_d;
      db_q   <= db_d;
      cnt_q  <= cnt_d;
    end
  end

  assign db_o   = db_q;
  assign rise_o = db_d & ~db_q;
  assign fall_o = ~db_d & db_q;

endmodule

// File: rtl/wb_keys.sv
// wb_keys: Wishbone responder exposing debounced buttons/switches with sticky W1C edge flags.
// Optional interrupt enable/pending registers and irq output are built when WB_KEYS_IRQ_EN is defined.
module wb_keys
  import wb_keys_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int NUM_BTN         = 4,
  parameter int NUM_SW          = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  wb_if.slave                wb,
  input  logic [NUM_BTN-1:0] btn,
  input  logic [NUM_SW-1:0]  sw,
  output logic               irq
);

  localparam int N = NUM_BTN + NUM_SW;

  logic [N-1:0] in_s;
  logic [N-1:0] db_s;
  logic [N-1:0] rise_evt_s;
  logic [N-1:0] fall_evt_s;

  logic [N-1:0] rise_q, rise_d;
  logic [N-1:0] fall_q, fall_d;
  logic [N-1:0] irq_en_q, irq_en_d;
  logic [N-1:0] pend_s;
  logic [N-1:0] wbits_s;
  logic [N-1:0] wmask_s;

  logic [31:0]  lane_mask_s;
  logic [31:0]  rdata_s;
  logic         req_s;
  logic         wr_s;
  reg_sel_e     sel_s;

  logic         ack_q, ack_d;
  logic [31:0]  dat_s_q, dat_s_d;
  logic         irq_q, irq_d;

  assign in_s = {sw, btn};

  for (genvar g = 0; g < N; g++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw_i  (in_s[g]),
      .db_o   (db_s[g]),
      .rise_o (rise_evt_s[g]),
      .fall_o (fall_evt_s[g])
    );
  end

  if (N < 32) begin : g_unused
    logic unused_s;
    assign unused_s = ^{wb.dat_m[31:N], lane_mask_s[31:N]};
  end

  // Bus request decode and byte-lane masked write data.
  always_comb begin
    req_s       = wb.cyc & wb.stb;
    wr_s        = req_s & wb.we;
    sel_s       = decode_reg(wb.adr);
    lane_mask_s = byte_mask(wb.sel);
    wmask_s     = lane_mask_s[N-1:0];
    wbits_s     = wb.dat_m[N-1:0] & wmask_s;
  end

  // Sticky edge flags: a same-cycle set event overrides the W1C clear.
  always_comb begin
    rise_d = rise_q | rise_evt_s;
    fall_d = fall_q | fall_evt_s;
    if (wr_s && (sel_s == SEL_RISE)) begin
      rise_d = (rise_q & ~wbits_s) | rise_evt_s;
    end else if (wr_s && (sel_s == SEL_FALL)) begin
      fall_d = (fall_q & ~wbits_s) | fall_evt_s;
    end else begin
      rise_d = rise_q | rise_evt_s;
      fall_d = fall_q | fall_evt_s;
    end
  end

`ifdef WB_KEYS_IRQ_EN
  // Interrupt enable register and pending/irq computation.
  always_comb begin
    irq_en_d = irq_en_q;
    if (wr_s && (sel_s == SEL_IRQ_EN)) begin
      irq_en_d = (irq_en_q & ~wmask_s) | wbits_s;
    end else begin
      irq_en_d = irq_en_q;
    end
    pend_s = (rise_q | fall_q) & irq_en_q;
    irq_d  = |pend_s;
  end
`else
  // Interrupt logic absent: enable and pending stay zero, irq never fires.
  always_comb begin
    irq_en_d = {N{1'b0}};
    pend_s   = {N{1'b0}};
    irq_d    = 1'b0;
  end
`endif

  // Read mux samples register state ahead of this cycle's updates.
  always_comb begin
    rdata_s = 32'h0000_0000;
    case (sel_s)
      SEL_DATA:     rdata_s[N-1:0] = db_s;
      SEL_RISE:     rdata_s[N-1:0] = rise_q;
      SEL_FALL:     rdata_s[N-1:0] = fall_q;
      SEL_IRQ_EN:   rdata_s[N-1:0] = irq_en_q;
      SEL_IRQ_PEND: rdata_s[N-1:0] = pend_s;
      SEL_NONE:     rdata_s = 32'h0000_0000;
      default:      rdata_s = 32'h0000_0000;
    endcase
    ack_d = req_s;
    if (req_s && !wb.we) begin
      dat_s_d = rdata_s;
    end else begin
      dat_s_d = 32'h0000_0000;
    end
  end

  // Register file and bus response flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_q   <= {N{1'b0}};
      fall_q   <= {N{1'b0}};
      irq_en_q <= {N{1'b0}};
      ack_q    <= 1'b0;
      dat_s_q  <= 32'h0000_0000;
      irq_q    <= 1'b0;
    end else begin
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      irq_en_q <= irq_en_d;
      ack_q    <= ack_d;
      dat_s_q  <= dat_s_d;
      irq_q    <= irq_d;
    end
  end

  assign wb.ack   = ack_q;
  assign wb.dat_s = dat_s_q;
  assign wb.stall = 1'b0;
  assign wb.err   = 1'b0;
  assign irq      = irq_q;

endmodule

// File: tb/tb_wb_keys.sv
// Directed scoreboard bench for wb_keys with DEBOUNCE_CYCLES=4 (covers both WB_KEYS_IRQ_EN builds).
module tb_wb_keys;
  import wb_keys_pkg::*;

  localparam int DB = 4;
  localparam int NB = 4;
  localparam int NS = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NB-1:0] btn;
  logic [NS-1:0] sw;
  logic          irq;

  wb_if wb ();

  wb_keys #(
    .DEBOUNCE_CYCLES(DB),
    .NUM_BTN        (NB),
    .NUM_SW         (NS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (wb),
    .btn   (btn),
    .sw    (sw),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];
  bit          rd_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    assert (got === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One clock; if a request was presented this cycle, its ack/data must appear after the edge.
  task automatic tick();
    logic  req_now;
    logic [31:0] e;
    string t;
    bit    r;
    req_now = wb.cyc & wb.stb & rst_n;
    @(posedge clk);
    #1;
    if (req_now) begin
      check("ack", {31'b0, wb.ack}, 32'h0000_0001);
      if (exp_q.size() == 0) begin
        err_cnt++;
        $error("FAIL scoreboard: observed empty queue expected entry");
      end else begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        r = rd_q.pop_front();
        if (r) check(t, wb.dat_s, e);
      end
    end else begin
      check("ack_idle", {31'b0, wb.ack}, 32'h0000_0000);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic rd(input logic [31:0] adr, input logic [31:0] exp, input string tag);
    wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = 1'b0;
    wb.adr = adr;  wb.sel = 4'hF; wb.dat_m = 32'h0;
    exp_q.push_back(exp); tag_q.push_back(tag); rd_q.push_back(1'b1);
    tick();
    wb.cyc = 1'b0; wb.stb = 1'b0;
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = 1'b1;
    wb.adr = adr;  wb.sel = sel;  wb.dat_m = dat;
    exp_q.push_back(32'h0); tag_q.push_back("wr"); rd_q.push_back(1'b0);
    tick();
    wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0;
  endtask

  localparam logic [31:0] A_DATA = WB_KEYS_BASE + 32'(DATA_OFS);
  localparam logic [31:0] A_RISE = WB_KEYS_BASE + 32'(RISE_OFS);
  localparam logic [31:0] A_FALL = WB_KEYS_BASE + 32'(FALL_OFS);
  localparam logic [31:0] A_IEN  = WB_KEYS_BASE + 32'(IRQ_EN_OFS);
  localparam logic [31:0] A_PEND = WB_KEYS_BASE + 32'(IRQ_PEND_OFS);

  initial begin
    wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0;
    wb.adr = 32'h0; wb.sel = 4'h0; wb.dat_m = 32'h0;
    btn = '0; sw = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", {31'b0, wb.ack}, 32'h0);
    check("rst_dat", wb.dat_s, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    rst_n = 1'b1;

    // Reset values of every register
    rd(A_DATA, 32'h0, "rst_data");
    rd(A_RISE, 32'h0, "rst_rise");
    rd(A_FALL, 32'h0, "rst_fall");
    rd(A_IEN,  32'h0, "rst_ien");
    rd(A_PEND, 32'h0, "rst_pend");
    check("irq_after_rst", {31'b0, irq}, 32'h0);

    // Three-cycle glitch on btn[0] must be rejected
    btn[0] = 1'b1; idle(3); btn[0] = 1'b0;
    idle(8);
    rd(A_DATA, 32'h0, "glitch_data");
    rd(A_RISE, 32'h0, "glitch_rise");

    // btn[2] held: DATA changes exactly DB+2 cycles after the raw change
    btn[2] = 1'b1; idle(5);
    rd(A_DATA, 32'h0,  "db_pre");
    rd(A_DATA, 32'h04, "db_post");
    rd(A_RISE, 32'h04, "rise_btn2");
    wr(A_RISE, 32'h04, 4'hF);
    rd(A_RISE, 32'h0,  "rise_cleared");
    rd(A_DATA, 32'h04, "data_kept");

    // sw[1] (bit 5) rise then fall; masked write leaves FALL untouched
    sw[1] = 1'b1; idle(8);
    rd(A_DATA, 32'h24, "data_sw1");
    rd(A_RISE, 32'h20, "rise_sw1");
    sw[1] = 1'b0; idle(8);
    rd(A_DATA, 32'h04, "data_sw1_low");
    rd(A_FALL, 32'h20, "fall_sw1");
    wr(A_FALL, 32'hFF, 4'b0000);
    rd(A_FALL, 32'h20, "fall_sel0");
    wr(A_FALL, 32'h20, 4'b0001);
    rd(A_FALL, 32'h0,  "fall_cleared");
    wr(A_RISE, 32'h20, 4'b0001);
    rd(A_RISE, 32'h0,  "rise_sw1_cleared");

`ifdef WB_KEYS_IRQ_EN
    wr(A_IEN, 32'h01, 4'hF);
    rd(A_IEN, 32'h01, "ien");
    btn[0] = 1'b1; idle(8);
    rd(A_PEND, 32'h01, "pend");
    check("irq_set", {31'b0, irq}, 32'h1);
    btn[0] = 1'b0; idle(8);
    rd(A_FALL, 32'h01, "fall_btn0");
    wr(A_RISE, 32'h01, 4'hF);
    check("irq_fall_still", {31'b0, irq}, 32'h1);
    wr(A_FALL, 32'h01, 4'hF);
    check("irq_at_ack", {31'b0, irq}, 32'h1);
    tick();
    check("irq_cleared", {31'b0, irq}, 32'h0);
    rd(A_PEND, 32'h0, "pend_cleared");
    wr(A_IEN, 32'h0, 4'hF);
`else
    wr(A_IEN, 32'hFF, 4'hF);
    rd(A_IEN, 32'h0, "ien_absent");
    btn[0] = 1'b1; idle(8);
    rd(A_PEND, 32'h0, "pend_absent");
    check("irq_absent", {31'b0, irq}, 32'h0);
    btn[0] = 1'b0; idle(8);
    rd(A_RISE, 32'h01, "rise_btn0");
    rd(A_FALL, 32'h01, "fall_btn0");
    wr(A_RISE, 32'h01, 4'hF);
    wr(A_FALL, 32'h01, 4'hF);
    rd(A_RISE, 32'h0, "rise_btn0_clr");
`endif

    // Clear of RISE[3] lands on the same edge as rise_evt[3]: set wins
    btn[3] = 1'b1; idle(5);
    wr(A_RISE, 32'h08, 4'hF);
    rd(A_RISE, 32'h08, "set_wins");
    wr(A_RISE, 32'h08, 4'hF);
    rd(A_RISE, 32'h0,  "rise3_clr");

    // Back-to-back reads, unmapped offset, ignored upper address bits
    rd(A_DATA,        32'h0C, "b2b_data");
    rd(32'h1000_1040, 32'h0,  "b2b_unmapped");
    rd(32'hABCD_E000, 32'h0C, "alias_data");
    idle(1);

    // Reset while an ack is pending drops it
    wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = 1'b0; wb.adr = A_DATA; wb.sel = 4'hF;
    @(posedge clk);
    #1;
    check("ack_before_rst", {31'b0, wb.ack}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("ack_dropped", {31'b0, wb.ack}, 32'h0);
    check("dat_dropped", wb.dat_s, 32'h0);
    wb.cyc = 1'b0; wb.stb = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Inputs held high through reset produce RISE DB+2 cycles after release
    idle(5);
    rd(A_RISE, 32'h0,  "post_rst_rise_pre");
    rd(A_RISE, 32'h0C, "post_rst_rise");
    rd(A_DATA, 32'h0C, "post_rst_data");
    rd(A_FALL, 32'h0,  "post_rst_fall");
    check("final_irq", {31'b0, irq}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
